icache_rsp: RTL and testbench
=============================

Name: icache_rsp

Overview:
- Direct-mapped instruction cache that acts as the responder to the fetch stage's instruction read port.
- The fetch stage supplies a read address. This block returns the instruction word in the same cycle on a hit.
- On a miss it stalls fetch through o_busy, which drives the fetch stage's hold input. It then refills the line word by word from backing memory using a single-outstanding request/response handshake.

Parameters:
- DEPTH, 32, number of cache lines; power of two, ≥2.
- LINE_WORDS, 4, 32-bit words per line; power of two, ≥2.

Ports:
- i_clk  in  1  global clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_req  in  1  fetch request valid this cycle
- i_req_addr  in  32  fetch byte address; bits [1:0] ignored
- i_flush  in  1  invalidate all lines (fence.i)
- o_rdata  out  32  instruction word; combinational
- o_vld  out  1  o_rdata valid (hit)
- o_busy  out  1  stall request to fetch; combinational
- o_mem_ren  out  1  backing-memory read request
- o_mem_addr  out  32  word-aligned backing-memory address
- i_mem_ready  in  1  backing memory accepts request
- i_mem_rdata  in  32  backing-memory data
- i_mem_valid  in  1  i_mem_rdata valid
- o_miss_cnt  out  16  saturating miss counter

Behaviour:
- Address split: [1:0] byte offset, then log2(LINE_WORDS) word select, then log2(DEPTH) index, remaining upper bits tag.
- Storage: data array, tag array, and a valid bit per line. Only the valid bits and control state are reset.
- hit = i_req & valid[idx] & (tag[idx] == addr tag) & (state == IDLE).
- o_rdata = data[idx][word] when hit, else 32'h00000033 (add x0,x0,x0 NOP).
- o_vld = hit.
- o_busy = (i_req & ~hit) | (state != IDLE).
- Reset (async, any state, including mid-fill):
  - state = IDLE, all valid bits = 0, word counter = 0, flush_pend = 0, o_miss_cnt = 0.
  - o_mem_ren = 0, o_mem_addr = 0, o_vld = 0, o_busy = 0, o_rdata = NOP.
  - Any in-flight memory response after reset release while in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT.
  - IDLE, i_req & miss & ~i_flush: latch line base (addr with word and byte bits zeroed), latch idx and tag, cnt = 0, increment o_miss_cnt (saturates at 16'hFFFF), go to REQ. o_busy is already high in this cycle.
  - REQ: o_mem_ren = 1, o_mem_addr = base + 4*cnt. Hold both stable until i_mem_ready = 1, then go to WAIT. o_mem_ren drops the cycle after acceptance.
  - WAIT: on i_mem_valid, write i_mem_rdata into data[idx][cnt].
    - If cnt == LINE_WORDS-1: set valid[idx] = ~(flush_pend | i_flush), write the tag, clear flush_pend, go to IDLE.
    - Else cnt++ and go to REQ.
  - i_mem_valid is ignored outside WAIT.
- Refill latency: the earliest hit is the cycle after the final word's i_mem_valid. With zero-wait memory (ready=1, valid the cycle after acceptance), a miss takes 2*LINE_WORDS+1 cycles to hit.
- Flush:
  - In IDLE: clears all valid bits at the clock edge. That cycle's lookup still uses the pre-flush valid bits; no refill starts that cycle.
  - During REQ or WAIT: sets flush_pend and clears all valid bits. The fill runs to completion to drain the outstanding response, but the line is not validated. Return to IDLE; the next request misses again.
- Requester contract: i_req_addr is held stable while o_busy = 1 (fetch holds the PC). The block uses only latched values during a fill, so it tolerates address changes there. i_req low during a fill does not abort it.
- Only one memory request is outstanding at any time; no new request is issued before i_mem_valid.

Test Plan:
- Reset then i_req=1, addr 0x0000_0040, memory returns 0x11,0x22,0x33,0x44 with ready=1 and 1-cycle valid:
  - o_busy=1 throughout; o_mem_addr steps 0x40, 0x44, 0x48, 0x4C.
  - Hit after 9 cycles with o_rdata=0x11; o_miss_cnt=1.
- After that fill, addr 0x4C: o_vld=1 and o_rdata=0x44 in the same cycle, o_busy=0, no o_mem_ren.
- Conflict: addr 0x0000_0240 (same index as 0x40, different tag, DEPTH=32, LINE_WORDS=4): miss and refill; afterwards 0x40 misses again; o_miss_cnt=3.
- Backpressure: hold i_mem_ready=0 for 5 cycles in REQ: o_mem_ren and o_mem_addr stay stable; a spurious i_mem_valid during REQ is not written.
- i_flush asserted during WAIT of word 2: fill completes, valid stays 0, o_busy drops; the same address re-misses and refetches.
- Assert i_rst_n=0 mid-fill (state WAIT): outputs return to reset values immediately; after release, the previously filling address misses and o_miss_cnt restarts at 1.

Source files
------------

// File: rtl/icache_rsp.sv
// Direct-mapped instruction cache answering the fetch stage; hits return data combinationally,
// misses stall fetch and refill the line one word at a time over a single-outstanding handshake.
module icache_rsp #(
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic [31:0] i_req_addr,
    input  logic        i_flush,
    output logic [31:0] o_rdata,
    output logic        o_vld,
    output logic        o_busy,
    output logic        o_mem_ren,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid,
    output logic [15:0] o_miss_cnt
);

    localparam int unsigned WORD_W = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned TAG_W  = 30 - WORD_W - IDX_W;
    localparam logic [31:0] NOP    = 32'h0000_0033;
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_t;

    state_t              state_q;
    logic [WORD_W-1:0]   cnt_q;
    logic [IDX_W-1:0]    idx_q;
    logic [TAG_W-1:0]    tag_fill_q;
    logic                flush_pend_q;
    logic [DEPTH-1:0]    valid_q;

    logic [TAG_W-1:0]    tag_mem  [DEPTH];
    logic [31:0]         data_mem [DEPTH*LINE_WORDS];

    logic [WORD_W-1:0]   req_word;
    logic [IDX_W-1:0]    req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic                hit;
    logic                mem_fire;
    logic                fill_last;
    logic                unused_addr_bits;

    assign req_word         = i_req_addr[2 +: WORD_W];
    assign req_idx          = i_req_addr[2 + WORD_W +: IDX_W];
    assign req_tag          = i_req_addr[31 -: TAG_W];
    assign unused_addr_bits = ^i_req_addr[1:0];

    assign hit = i_req & valid_q[req_idx] & (tag_mem[req_idx] == req_tag) & (state_q == StIdle);

    assign o_vld   = hit;
    assign o_rdata = hit ? data_mem[{req_idx, req_word}] : NOP;
    assign o_busy  = (i_req & ~hit) | (state_q != StIdle);

    assign mem_fire  = (state_q == StWait) & i_mem_valid;
    assign fill_last = (cnt_q == LAST_WORD);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            idx_q        <= '0;
            tag_fill_q   <= '0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
            o_mem_ren    <= 1'b0;
            o_mem_addr   <= '0;
            o_miss_cnt   <= '0;
        end else begin
            if (i_flush) valid_q <= '0;
            case (state_q)
                StIdle: begin
                    // A flush cycle never launches a refill; the request retries next cycle.
                    if (i_req && !hit && !i_flush) begin
                        idx_q      <= req_idx;
                        tag_fill_q <= req_tag;
                        cnt_q      <= '0;
                        o_mem_addr <= {i_req_addr[31:WORD_W+2], {(WORD_W + 2){1'b0}}};
                        o_mem_ren  <= 1'b1;
                        state_q    <= StReq;
                        if (o_miss_cnt != 16'hFFFF) o_miss_cnt <= o_miss_cnt + 16'd1;
                    end
                end
                StReq: begin
                    if (i_flush) flush_pend_q <= 1'b1;
                    if (i_mem_ready) begin
                        o_mem_ren <= 1'b0;
                        state_q   <= StWait;
                    end
                end
                StWait: begin
                    if (i_flush) flush_pend_q <= 1'b1;
                    if (i_mem_valid) begin
                        if (fill_last) begin
                            // A flush seen at any point during the fill leaves the line invalid.
                            valid_q[idx_q] <= ~(flush_pend_q | i_flush);
                            flush_pend_q   <= 1'b0;
                            state_q        <= StIdle;
                        end else begin
                            cnt_q      <= cnt_q + WORD_W'(1);
                            o_mem_addr <= o_mem_addr + 32'd4;
                            o_mem_ren  <= 1'b1;
                            state_q    <= StReq;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_fire) data_mem[{idx_q, cnt_q}] <= i_mem_rdata;
        if (mem_fire && fill_last) tag_mem[idx_q] <= tag_fill_q;
    end

endmodule

// File: tb/tb_icache_rsp.sv
// Directed bench for icache_rsp: a negedge-driven memory responder plus one task per scenario.
module tb_icache_rsp;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_req;
    logic [31:0] i_req_addr;
    logic        i_flush;
    logic [31:0] o_rdata;
    logic        o_vld;
    logic        o_busy;
    logic        o_mem_ren;
    logic [31:0] o_mem_addr;
    logic        i_mem_ready;
    logic [31:0] i_mem_rdata;
    logic        i_mem_valid;
    logic [15:0] o_miss_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    bit          mem_ready_en = 1'b1;
    bit          spur_en      = 1'b0;
    bit          got_accept   = 1'b0;
    logic [31:0] acc_addr     = '0;

    localparam logic [31:0] NOP = 32'h0000_0033;

    icache_rsp #(.DEPTH(32), .LINE_WORDS(4)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req       (i_req),
        .i_req_addr  (i_req_addr),
        .i_flush     (i_flush),
        .o_rdata     (o_rdata),
        .o_vld       (o_vld),
        .o_busy      (o_busy),
        .o_mem_ren   (o_mem_ren),
        .o_mem_addr  (o_mem_addr),
        .i_mem_ready (i_mem_ready),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_valid (i_mem_valid),
        .o_miss_cnt  (o_miss_cnt)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h40:  return 32'h11;
            32'h44:  return 32'h22;
            32'h48:  return 32'h33;
            32'h4C:  return 32'h44;
            default: return {16'hD000, a[15:0]};
        endcase
    endfunction

    // Memory responder: valid arrives the cycle after acceptance.
    initial begin
        i_mem_ready = 1'b0;
        i_mem_valid = 1'b0;
        i_mem_rdata = '0;
        forever begin
            @(negedge i_clk);
            if (got_accept) begin
                i_mem_valid = 1'b1;
                i_mem_rdata = mem_word(acc_addr);
            end else if (spur_en) begin
                i_mem_valid = 1'b1;
                i_mem_rdata = 32'hDEAD_BEEF;
            end else begin
                i_mem_valid = 1'b0;
                i_mem_rdata = '0;
            end
            i_mem_ready = mem_ready_en;
            got_accept  = o_mem_ren && i_mem_ready;
            acc_addr    = o_mem_addr;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_vld(input int max_cycles, output bit ok);
        int c;
        c = 0;
        while (!o_vld && c < max_cycles) begin
            tick();
            c++;
        end
        ok = o_vld;
    endtask

    task automatic test_reset();
        i_rst_n    = 1'b0;
        i_req      = 1'b0;
        i_req_addr = '0;
        i_flush    = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        n_checks++; if (o_mem_ren !== 1'b0) begin n_fail++; $display("FAIL reset_ren: got %b want 0", o_mem_ren); end
        n_checks++; if (o_mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", o_mem_addr); end
        n_checks++; if (o_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", o_vld); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        n_checks++; if (o_rdata !== NOP) begin n_fail++; $display("FAIL reset_rdata: got %h want %h", o_rdata, NOP); end
        n_checks++; if (o_miss_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_miss: got %0d want 0", o_miss_cnt); end
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_first_fill();
        logic [31:0] addrs [8];
        logic [31:0] exp_addrs [4];
        int          naddr;
        int          hit_cyc;
        bit          busy_drop;
        exp_addrs = '{32'h40, 32'h44, 32'h48, 32'h4C};
        naddr     = 0;
        hit_cyc   = -1;
        busy_drop = 1'b0;
        i_req      = 1'b1;
        i_req_addr = 32'h40;
        #1;
        n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL miss_busy: got %b want 1", o_busy); end
        n_checks++; if (o_vld !== 1'b0) begin n_fail++; $display("FAIL miss_vld: got %b want 0", o_vld); end
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (o_vld) begin
                hit_cyc = c;
                break;
            end
            if (!o_busy) busy_drop = 1'b1;
            if (o_mem_ren && naddr < 8) begin
                addrs[naddr] = o_mem_addr;
                naddr++;
            end
        end
        n_checks++; if (hit_cyc != 9) begin n_fail++; $display("FAIL fill_latency: got %0d want 9", hit_cyc); end
        n_checks++; if (busy_drop) begin n_fail++; $display("FAIL fill_busy: got drop want held"); end
        n_checks++; if (naddr != 4) begin n_fail++; $display("FAIL fill_nreq: got %0d want 4", naddr); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= naddr || addrs[i] !== exp_addrs[i]) begin
                n_fail++;
                $display("FAIL fill_addr%0d: got %h want %h", i, (i < naddr) ? addrs[i] : 32'hX, exp_addrs[i]);
            end
        end
        n_checks++; if (o_rdata !== 32'h11) begin n_fail++; $display("FAIL fill_rdata: got %h want 11", o_rdata); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL fill_busy_end: got %b want 0", o_busy); end
        n_checks++; if (o_miss_cnt !== 16'd1) begin n_fail++; $display("FAIL fill_miss: got %0d want 1", o_miss_cnt); end
    endtask

    task automatic test_hit_same_cycle();
        logic [31:0] exp_data [4];
        exp_data = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int w = 3; w >= 0; w--) begin
            i_req_addr = 32'h40 + 32'(4 * w);
            #1;
            n_checks++;
            if (o_vld !== 1'b1 || o_rdata !== exp_data[w] || o_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL hit_word%0d: got vld=%b busy=%b data=%h want vld=1 busy=0 data=%h",
                         w, o_vld, o_busy, o_rdata, exp_data[w]);
            end
        end
        tick();
        n_checks++; if (o_mem_ren !== 1'b0) begin n_fail++; $display("FAIL hit_ren: got %b want 0", o_mem_ren); end
        n_checks++; if (o_miss_cnt !== 16'd1) begin n_fail++; $display("FAIL hit_miss: got %0d want 1", o_miss_cnt); end
    endtask

    task automatic test_conflict();
        bit ok;
        i_req_addr = 32'h240;
        #1;
        n_checks++; if (o_vld !== 1'b0 || o_busy !== 1'b1) begin n_fail++; $display("FAIL conf_miss: got vld=%b busy=%b want 0/1", o_vld, o_busy); end
        wait_vld(30, ok);
        n_checks++; if (!ok || o_rdata !== 32'hD000_0240) begin n_fail++; $display("FAIL conf_fill: got ok=%b data=%h want 1/d0000240", ok, o_rdata); end
        i_req_addr = 32'h40;
        #1;
        n_checks++; if (o_vld !== 1'b0 || o_busy !== 1'b1) begin n_fail++; $display("FAIL conf_evict: got vld=%b busy=%b want 0/1", o_vld, o_busy); end
        wait_vld(30, ok);
        n_checks++; if (!ok || o_rdata !== 32'h11) begin n_fail++; $display("FAIL conf_refill: got ok=%b data=%h want 1/11", ok, o_rdata); end
        n_checks++; if (o_miss_cnt !== 16'd3) begin n_fail++; $display("FAIL conf_miss_cnt: got %0d want 3", o_miss_cnt); end
    endtask

    task automatic test_backpressure();
        bit ok;
        mem_ready_en = 1'b0;
        i_req_addr   = 32'h80;
        tick();
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (o_mem_ren !== 1'b1 || o_mem_addr !== 32'h80 || o_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got ren=%b addr=%h busy=%b want 1/00000080/1", k, o_mem_ren, o_mem_addr, o_busy);
            end
            spur_en = (k == 1);
            tick();
        end
        spur_en      = 1'b0;
        mem_ready_en = 1'b1;
        wait_vld(30, ok);
        n_checks++; if (!ok || o_rdata !== 32'hD000_0080) begin n_fail++; $display("FAIL bp_word0: got ok=%b data=%h want 1/d0000080", ok, o_rdata); end
        // Spurious valid while idle must not overwrite the last filled word.
        spur_en = 1'b1;
        tick();
        tick();
        spur_en    = 1'b0;
        i_req_addr = 32'h8C;
        #1;
        n_checks++; if (o_vld !== 1'b1 || o_rdata !== 32'hD000_008C) begin n_fail++; $display("FAIL bp_idle_spur: got vld=%b data=%h want 1/d000008c", o_vld, o_rdata); end
        n_checks++; if (o_miss_cnt !== 16'd4) begin n_fail++; $display("FAIL bp_miss_cnt: got %0d want 4", o_miss_cnt); end
    endtask

    task automatic test_flush_wait();
        bit ok;
        bit found;
        i_req_addr = 32'hC0;
        tick();
        i_req = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (o_mem_ren && o_mem_addr == 32'hC8) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL fl_reach_word2: got none want req at 000000c8"); end
        tick();
        n_checks++; if (o_mem_ren !== 1'b0 || o_busy !== 1'b1) begin n_fail++; $display("FAIL fl_in_wait: got ren=%b busy=%b want 0/1", o_mem_ren, o_busy); end
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (!o_busy) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL fl_busy_drop: got busy=1 want 0"); end
        i_req      = 1'b1;
        i_req_addr = 32'h40;
        #1;
        n_checks++; if (o_vld !== 1'b0) begin n_fail++; $display("FAIL fl_other_line: got vld=%b want 0", o_vld); end
        i_req_addr = 32'hC0;
        #1;
        n_checks++; if (o_vld !== 1'b0 || o_busy !== 1'b1) begin n_fail++; $display("FAIL fl_remiss: got vld=%b busy=%b want 0/1", o_vld, o_busy); end
        wait_vld(30, ok);
        n_checks++; if (!ok || o_rdata !== 32'hD000_00C0) begin n_fail++; $display("FAIL fl_refetch: got ok=%b data=%h want 1/d00000c0", ok, o_rdata); end
        n_checks++; if (o_miss_cnt !== 16'd6) begin n_fail++; $display("FAIL fl_miss_cnt: got %0d want 6", o_miss_cnt); end
    endtask

    task automatic test_reset_mid_fill();
        bit ok;
        i_req_addr = 32'h100;
        tick();
        tick();
        n_checks++; if (o_mem_ren !== 1'b0 || o_busy !== 1'b1) begin n_fail++; $display("FAIL rm_in_wait: got ren=%b busy=%b want 0/1", o_mem_ren, o_busy); end
        i_rst_n = 1'b0;
        i_req   = 1'b0;
        #1;
        n_checks++;
        if (o_mem_ren !== 1'b0 || o_mem_addr !== 32'h0 || o_vld !== 1'b0 || o_busy !== 1'b0 ||
            o_rdata !== NOP || o_miss_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL rm_async: got ren=%b addr=%h vld=%b busy=%b data=%h miss=%0d want reset values",
                     o_mem_ren, o_mem_addr, o_vld, o_busy, o_rdata, o_miss_cnt);
        end
        #2;
        i_rst_n = 1'b1;
        tick();
        tick();
        n_checks++; if (o_busy !== 1'b0 || o_mem_ren !== 1'b0) begin n_fail++; $display("FAIL rm_ignore_rsp: got busy=%b ren=%b want 0/0", o_busy, o_mem_ren); end
        i_req      = 1'b1;
        i_req_addr = 32'hC0;
        #1;
        n_checks++; if (o_vld !== 1'b0) begin n_fail++; $display("FAIL rm_valid_clr: got vld=%b want 0", o_vld); end
        i_req_addr = 32'h100;
        #1;
        n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL rm_remiss: got busy=%b want 1", o_busy); end
        wait_vld(30, ok);
        n_checks++; if (!ok || o_rdata !== 32'hD000_0100) begin n_fail++; $display("FAIL rm_refill: got ok=%b data=%h want 1/d0000100", ok, o_rdata); end
        n_checks++; if (o_miss_cnt !== 16'd1) begin n_fail++; $display("FAIL rm_miss_cnt: got %0d want 1", o_miss_cnt); end
    endtask

    initial begin
        test_reset();
        test_first_fill();
        test_hit_same_cycle();
        test_conflict();
        test_backpressure();
        test_flush_wait();
        test_reset_mid_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
